pattern_collector: RTL and testbench

- Receiving end of the pattern_solver result stream.
- Accepts 4-bit iteration results from NUM_SOLVERS row-interleaved solvers.
- Reconstructs each pixel's (column, row) from per-lane raster counters and buffers results in per-lane FIFOs.
- Writes pixels to the frame buffer through a round-robin-arbitrated, Avalon-style write master, and flags frame completion.

---
 rtl/pattern_collector.sv | 233 +++++++++++++++++++++++
 tb/tb_pattern_collector.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pattern_collector.sv
// pattern_collector: gathers per-lane solver results, rebuilds pixel
// addresses from raster counters, buffers them in per-lane FIFOs and
// drains them through a round-robin arbitrated Avalon-style write master.
module pattern_collector #(
  parameter int unsigned NUM_SOLVERS = 1,
  parameter int unsigned NUM_COLUMNS = 640,
  parameter int unsigned NUM_ROWS    = 480,
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned ADDR_WIDTH  = 19,
  parameter int unsigned BASE_ADDR   = 0
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       start,
  input  logic [4*NUM_SOLVERS-1:0]   solver_out,
  input  logic [NUM_SOLVERS-1:0]     solver_ready,
  output logic [ADDR_WIDTH-1:0]      mem_address,
  output logic [7:0]                 mem_writedata,
  output logic                       mem_write,
  input  logic                       mem_waitrequest,
  output logic                       busy,
  output logic                       frame_done,
  output logic                       overflow
);

  localparam int unsigned CW = $clog2(NUM_COLUMNS + 1);
  localparam int unsigned RW = $clog2(NUM_ROWS + NUM_SOLVERS + 1);
  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned LW = (NUM_SOLVERS > 1) ? $clog2(NUM_SOLVERS) : 1;
  localparam int unsigned EW = ADDR_WIDTH + 4;

  localparam logic [ADDR_WIDTH-1:0] BASE_A     = ADDR_WIDTH'(BASE_ADDR);
  localparam logic [ADDR_WIDTH-1:0] ROW_STEP   = ADDR_WIDTH'(NUM_SOLVERS * NUM_COLUMNS);
  localparam logic [CW-1:0]         LAST_COL   = CW'(NUM_COLUMNS - 1);
  localparam logic [CW-1:0]         COL_ONE    = CW'(1);
  localparam logic [RW-1:0]         ROW_STRIDE = RW'(NUM_SOLVERS);
  localparam logic [RW-1:0]         ROW_LIMIT  = RW'(NUM_ROWS);
  localparam logic [PW:0]           DEPTH_C    = (PW+1)'(FIFO_DEPTH);
  localparam logic [PW:0]           PTR_ONE    = (PW+1)'(1);
  localparam logic [LW-1:0]         LAST_LANE  = LW'(NUM_SOLVERS - 1);

  // Per-lane raster position and FIFO state
  logic [CW-1:0]         col_q   [NUM_SOLVERS];
  logic [CW-1:0]         col_d   [NUM_SOLVERS];
  logic [RW-1:0]         row_q   [NUM_SOLVERS];
  logic [RW-1:0]         row_d   [NUM_SOLVERS];
  logic [ADDR_WIDTH-1:0] rbase_q [NUM_SOLVERS];
  logic [ADDR_WIDTH-1:0] rbase_d [NUM_SOLVERS];
  logic [PW:0]           wp_q    [NUM_SOLVERS];
  logic [PW:0]           wp_d    [NUM_SOLVERS];
  logic [PW:0]           rp_q    [NUM_SOLVERS];
  logic [PW:0]           rp_d    [NUM_SOLVERS];
  logic [EW-1:0]         fifo_q  [NUM_SOLVERS][FIFO_DEPTH];
  logic [EW-1:0]         cap_entry [NUM_SOLVERS];
  logic [EW-1:0]         head      [NUM_SOLVERS];
  logic [NUM_SOLVERS-1:0] done_q, done_d;
  logic [NUM_SOLVERS-1:0] capture, empty, full, avail, pop, push, wr_en, drop;

  // Output register and global flags
  logic                  out_valid_q, out_valid_d;
  logic [ADDR_WIDTH-1:0] out_addr_q, out_addr_d;
  logic [3:0]            out_data_q, out_data_d;
  logic [LW-1:0]         last_q, last_d;
  logic                  busy_q, busy_d;
  logic                  fdone_q, fdone_d;
  logic                  ovf_q, ovf_d;

  logic                  load_en, found, accept;
  logic [LW-1:0]         gidx;
  logic [EW-1:0]         sel_entry;

  assign accept        = out_valid_q && !mem_waitrequest;
  assign mem_write     = out_valid_q;
  assign mem_address   = out_addr_q;
  assign mem_writedata = {out_data_q, out_data_q};
  assign busy          = busy_q;
  assign frame_done    = fdone_q;
  assign overflow      = ovf_q;

  // Lane capture qualification, FIFO status and head selection
  always_comb begin
    for (int unsigned i = 0; i < NUM_SOLVERS; i++) begin
      capture[i]   = busy_q && !start && solver_ready[i] && !done_q[i];
      cap_entry[i] = {rbase_q[i] + ADDR_WIDTH'(col_q[i]), solver_out[4*i +: 4]};
      empty[i]     = (wp_q[i] == rp_q[i]);
      full[i]      = ((wp_q[i] - rp_q[i]) == DEPTH_C);
      // An empty FIFO presents the incoming result directly so an idle
      // lane reaches the bus one cycle after capture.
      avail[i]     = !empty[i] || capture[i];
      head[i]      = empty[i] ? cap_entry[i] : fifo_q[i][rp_q[i][PW-1:0]];
    end
  end

  // Round-robin grant starting one past the last granted lane
  always_comb begin
    int unsigned target;
    found     = 1'b0;
    gidx      = '0;
    sel_entry = '0;
    target    = 0;
    pop       = '0;
    load_en   = !start && (!out_valid_q || !mem_waitrequest);
    for (int unsigned k = 1; k <= NUM_SOLVERS; k++) begin
      target = 32'(last_q) + k;
      if (target >= NUM_SOLVERS) target = target - NUM_SOLVERS;
      for (int unsigned i = 0; i < NUM_SOLVERS; i++) begin
        if (load_en && !found && avail[i] && (i == target)) begin
          found     = 1'b1;
          gidx      = LW'(i);
          sel_entry = head[i];
        end
      end
    end
    for (int unsigned i = 0; i < NUM_SOLVERS; i++) begin
      pop[i] = found && (gidx == LW'(i));
    end
  end

  // Lane next state: FIFO pointers and raster counters
  always_comb begin
    for (int unsigned i = 0; i < NUM_SOLVERS; i++) begin
      push[i]    = capture[i] && (!full[i] || pop[i]);
      drop[i]    = capture[i] && !push[i];
      // Push and pop into an empty FIFO is a pass-through; pointers stay put.
      wr_en[i]   = push[i] && !(empty[i] && pop[i]);
      wp_d[i]    = wp_q[i];
      rp_d[i]    = rp_q[i];
      col_d[i]   = col_q[i];
      row_d[i]   = row_q[i];
      rbase_d[i] = rbase_q[i];
      done_d[i]  = done_q[i];
      if (start) begin
        wp_d[i]    = '0;
        rp_d[i]    = '0;
        col_d[i]   = '0;
        row_d[i]   = RW'(i);
        rbase_d[i] = BASE_A + ADDR_WIDTH'(i * NUM_COLUMNS);
        done_d[i]  = (i >= NUM_ROWS);
      end else begin
        if (wr_en[i]) wp_d[i] = wp_q[i] + PTR_ONE;
        if (pop[i] && !empty[i]) rp_d[i] = rp_q[i] + PTR_ONE;
        // Counters move on every accepted pulse, dropped or not.
        if (capture[i]) begin
          if (col_q[i] == LAST_COL) begin
            col_d[i]   = '0;
            row_d[i]   = row_q[i] + ROW_STRIDE;
            rbase_d[i] = rbase_q[i] + ROW_STEP;
            if ((row_q[i] + ROW_STRIDE) >= ROW_LIMIT) done_d[i] = 1'b1;
          end else begin
            col_d[i] = col_q[i] + COL_ONE;
          end
        end
      end
    end
  end

  // Output register, arbitration pointer and frame flags
  always_comb begin
    out_valid_d = out_valid_q;
    out_addr_d  = out_addr_q;
    out_data_d  = out_data_q;
    last_d      = last_q;
    busy_d      = busy_q;
    fdone_d     = fdone_q;
    ovf_d       = ovf_q || (|drop);
    if (start) begin
      // A stalled write survives the restart; everything queued does not.
      out_valid_d = out_valid_q && mem_waitrequest;
      last_d      = LAST_LANE;
      busy_d      = 1'b1;
      fdone_d     = 1'b0;
      ovf_d       = 1'b0;
    end else begin
      if (found) begin
        out_valid_d = 1'b1;
        out_addr_d  = sel_entry[EW-1:4];
        out_data_d  = sel_entry[3:0];
        last_d      = gidx;
      end else if (accept) begin
        out_valid_d = 1'b0;
      end
      if (busy_q && (&done_q) && (&empty) && (!out_valid_q || accept)) begin
        fdone_d = 1'b1;
        busy_d  = 1'b0;
      end
    end
  end

  // State registers with asynchronous active-low reset
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < NUM_SOLVERS; i++) begin
        col_q[i]   <= '0;
        row_q[i]   <= RW'(i);
        rbase_q[i] <= BASE_A + ADDR_WIDTH'(i * NUM_COLUMNS);
        wp_q[i]    <= '0;
        rp_q[i]    <= '0;
        done_q[i]  <= (i >= NUM_ROWS);
      end
      out_valid_q <= 1'b0;
      out_addr_q  <= '0;
      out_data_q  <= '0;
      last_q      <= LAST_LANE;
      busy_q      <= 1'b0;
      fdone_q     <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < NUM_SOLVERS; i++) begin
        col_q[i]   <= col_d[i];
        row_q[i]   <= row_d[i];
        rbase_q[i] <= rbase_d[i];
        wp_q[i]    <= wp_d[i];
        rp_q[i]    <= rp_d[i];
        done_q[i]  <= done_d[i];
      end
      out_valid_q <= out_valid_d;
      out_addr_q  <= out_addr_d;
      out_data_q  <= out_data_d;
      last_q      <= last_d;
      busy_q      <= busy_d;
      fdone_q     <= fdone_d;
      ovf_q       <= ovf_d;
    end
  end

  // FIFO storage writes
  always_ff @(posedge clock) begin
    for (int unsigned i = 0; i < NUM_SOLVERS; i++) begin
      if (wr_en[i]) fifo_q[i][wp_q[i][PW-1:0]] <= cap_entry[i];
    end
  end

endmodule

// File: tb/tb_pattern_collector.sv
// Directed bench for pattern_collector on a 2-lane 4x3 frame.
module tb_pattern_collector;

  localparam int unsigned AW = 8;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [7:0]    solver_out = '0;
  logic [1:0]    solver_ready = '0;
  logic          mem_waitrequest = 1'b0;
  logic [AW-1:0] mem_address;
  logic [7:0]    mem_writedata;
  logic          mem_write;
  logic          busy;
  logic          frame_done;
  logic          overflow;

  int n_checks = 0;
  int n_pass   = 0;

  logic [AW-1:0] wq_a[$];
  logic [7:0]    wq_d[$];
  logic [AW-1:0] exp_a[$];
  logic [7:0]    exp_d[$];

  pattern_collector #(
    .NUM_SOLVERS(2),
    .NUM_COLUMNS(4),
    .NUM_ROWS(3),
    .FIFO_DEPTH(4),
    .ADDR_WIDTH(AW),
    .BASE_ADDR(0)
  ) dut (
    .clock(clock),
    .reset(reset),
    .start(start),
    .solver_out(solver_out),
    .solver_ready(solver_ready),
    .mem_address(mem_address),
    .mem_writedata(mem_writedata),
    .mem_write(mem_write),
    .mem_waitrequest(mem_waitrequest),
    .busy(busy),
    .frame_done(frame_done),
    .overflow(overflow)
  );

  always #5 clock = ~clock;

  // Record every accepted write (pre-edge values)
  always @(posedge clock) begin
    if (mem_write && !mem_waitrequest) begin
      wq_a.push_back(mem_address);
      wq_d.push_back(mem_writedata);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clock);
  endtask

  task automatic pulse(input logic [1:0] rdy, input logic [3:0] d0, input logic [3:0] d1);
    solver_ready = rdy;
    solver_out   = {d1, d0};
    tick();
    solver_ready = '0;
    tick();
    tick();
  endtask

  task automatic expect_w(input logic [AW-1:0] a, input logic [7:0] d);
    exp_a.push_back(a);
    exp_d.push_back(d);
  endtask

  task automatic check_writes(input string tag);
    check($sformatf("%s_count", tag), wq_a.size(), exp_a.size());
    for (int i = 0; i < exp_a.size(); i++) begin
      if (i < wq_a.size()) begin
        check($sformatf("%s_addr%0d", tag, i), 32'(wq_a[i]), 32'(exp_a[i]));
        check($sformatf("%s_data%0d", tag, i), 32'(wq_d[i]), 32'(exp_d[i]));
      end
    end
    wq_a.delete();
    wq_d.delete();
    exp_a.delete();
    exp_d.delete();
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    // Reset state
    #1 reset = 1'b0;
    #1;
    check("rst_mem_write", mem_write, 0);
    check("rst_busy", busy, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_overflow", overflow, 0);
    tick();
    reset = 1'b1;

    // Pulses while disarmed are ignored
    pulse(2'b11, 4'h3, 4'h5);
    check("disarmed_busy", busy, 0);
    check("disarmed_mem_write", mem_write, 0);
    check_writes("disarmed");

    // Full frame with spaced single-lane pulses: address equals pulse index
    do_start();
    check("a_busy", busy, 1);
    check("a_frame_done0", frame_done, 0);
    for (int p = 0; p < 12; p++) begin
      logic [3:0] d;
      d = 4'((p * 7 + 3) % 16);
      if (p >= 4 && p < 8) begin
        solver_ready = 2'b10;
        solver_out   = {d, 4'h0};
      end else begin
        solver_ready = 2'b01;
        solver_out   = {4'h0, d};
      end
      expect_w(AW'(p), {d, d});
      tick();
      solver_ready = '0;
      if (p == 11) begin
        check("a_last_write", mem_write, 1);
        check("a_frame_done_early", frame_done, 0);
      end
      tick();
      if (p == 11) begin
        check("a_frame_done", frame_done, 1);
        check("a_busy_low", busy, 0);
        check("a_write_low", mem_write, 0);
      end
      tick();
    end
    check_writes("frameA");
    check("a_overflow", overflow, 0);
    pulse(2'b11, 4'h7, 4'h7);
    check("a_done_hold", frame_done, 1);
    check_writes("after_done");

    // Collisions, extra pulse on a finished lane
    do_start();
    check("b_frame_done_clr", frame_done, 0);
    pulse(2'b11, 4'h1, 4'h2);  expect_w(8'd0, 8'h11); expect_w(8'd4, 8'h22);
    pulse(2'b01, 4'h3, 4'h0);  expect_w(8'd1, 8'h33);
    pulse(2'b11, 4'h4, 4'h5);  expect_w(8'd5, 8'h55); expect_w(8'd2, 8'h44);
    pulse(2'b10, 4'h0, 4'h6);  expect_w(8'd6, 8'h66);
    pulse(2'b10, 4'h0, 4'h7);  expect_w(8'd7, 8'h77);
    pulse(2'b10, 4'h0, 4'h8);
    check("b_extra_no_done", frame_done, 0);
    check("b_extra_busy", busy, 1);
    pulse(2'b01, 4'h9, 4'h0);  expect_w(8'd3, 8'h99);
    pulse(2'b01, 4'hA, 4'h0);  expect_w(8'd8, 8'hAA);
    pulse(2'b01, 4'hB, 4'h0);  expect_w(8'd9, 8'hBB);
    pulse(2'b01, 4'hC, 4'h0);  expect_w(8'd10, 8'hCC);
    pulse(2'b01, 4'hD, 4'h0);  expect_w(8'd11, 8'hDD);
    check("b_frame_done", frame_done, 1);
    check("b_busy", busy, 0);
    check("b_overflow", overflow, 0);
    check_writes("collide");

    // Stalled bus: held outputs, FIFO fills, sixth pulse dropped
    do_start();
    for (int i = 0; i < 8; i++) begin
      mem_waitrequest = 1'b1;
      solver_ready    = (i < 6) ? 2'b01 : 2'b00;
      solver_out      = {4'h0, 4'(i + 1)};
      tick();
      check($sformatf("c_hold_write%0d", i), mem_write, 1);
      check($sformatf("c_hold_addr%0d", i), mem_address, 0);
      check($sformatf("c_hold_data%0d", i), mem_writedata, 8'h11);
    end
    solver_ready    = '0;
    mem_waitrequest = 1'b0;
    check("c_overflow", overflow, 1);
    tick(); check("c_stream_a1", mem_address, 1); check("c_stream_d1", mem_writedata, 8'h22);
    tick(); check("c_stream_a2", mem_address, 2); check("c_stream_d2", mem_writedata, 8'h33);
    tick(); check("c_stream_a3", mem_address, 3); check("c_stream_d3", mem_writedata, 8'h44);
    tick(); check("c_stream_a8", mem_address, 8); check("c_stream_d8", mem_writedata, 8'h55);
    check("c_stream_wr", mem_write, 1);
    tick(); check("c_drained", mem_write, 0);
    pulse(2'b01, 4'h7, 4'h0);
    pulse(2'b01, 4'h8, 4'h0);
    check("c_not_done", frame_done, 0);
    expect_w(8'd0, 8'h11); expect_w(8'd1, 8'h22); expect_w(8'd2, 8'h33);
    expect_w(8'd3, 8'h44); expect_w(8'd8, 8'h55); expect_w(8'd10, 8'h77);
    expect_w(8'd11, 8'h88);
    check_writes("stall");

    // Restart while a write is stalled and another result is queued
    mem_waitrequest = 1'b1;
    solver_ready    = 2'b10;
    solver_out      = {4'h9, 4'h0};
    tick();
    solver_out      = {4'hA, 4'h0};
    tick();
    solver_ready    = 2'b01;
    solver_out      = {4'h0, 4'h5};
    start           = 1'b1;
    tick();
    start           = 1'b0;
    solver_ready    = '0;
    check("e_held_write", mem_write, 1);
    check("e_held_addr", mem_address, 4);
    check("e_held_data", mem_writedata, 8'h99);
    check("e_overflow_clr", overflow, 0);
    check("e_busy", busy, 1);
    tick();
    check("e_still_addr", mem_address, 4);
    mem_waitrequest = 1'b0;
    tick();
    check("e_accepted", mem_write, 0);
    tick();
    check("e_no_old", mem_write, 0);
    pulse(2'b01, 4'h3, 4'h0);
    expect_w(8'd4, 8'h99); expect_w(8'd0, 8'h33);
    check_writes("restart");

    // Asynchronous reset in the middle of a stalled write
    mem_waitrequest = 1'b1;
    for (int i = 0; i < 6; i++) begin
      solver_ready = 2'b01;
      solver_out   = {4'h0, 4'(i)};
      tick();
    end
    solver_ready = '0;
    check("f_pre_overflow", overflow, 1);
    check("f_pre_write", mem_write, 1);
    #2 reset = 1'b0;
    #1;
    check("f_rst_write", mem_write, 0);
    check("f_rst_busy", busy, 0);
    check("f_rst_done", frame_done, 0);
    check("f_rst_overflow", overflow, 0);
    tick();
    reset = 1'b1;
    mem_waitrequest = 1'b0;
    pulse(2'b11, 4'h2, 4'h2);
    check("f_ignored_busy", busy, 0);
    check("f_ignored_write", mem_write, 0);
    check_writes("post_reset_idle");
    do_start();
    pulse(2'b01, 4'h6, 4'h0);
    expect_w(8'd0, 8'h66);
    check_writes("post_reset_start");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
